// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, stall encoding, sl_bus bit positions and
// packed views of the EX->MEM, MEM->WB and MEM->ID buses for the MEM stage.
package mem_stage_pkg;

    // Bus widths
    localparam int EX_TO_MEM_WD = 90;
    localparam int MEM_TO_WB_WD = 70;
    localparam int MEM_TO_ID_WD = 38;

    // Stall vector: one bit per pipeline stage, Stop = 1
    localparam int   STALL_BUS = 6;
    localparam int   STALL_MEM = 3;
    localparam int   STALL_WB  = 4;
    localparam logic STOP      = 1'b1;
    localparam logic NO_STOP   = 1'b0;

    // sl_bus bit indices; bits [5:0] are reserved
    localparam int SL_LW  = 13;
    localparam int SL_SW  = 12;
    localparam int SL_LB  = 11;
    localparam int SL_LBU = 10;
    localparam int SL_LH  = 9;
    localparam int SL_LHU = 8;
    localparam int SL_SB  = 7;
    localparam int SL_SH  = 6;

    // EX->MEM bus, MSB first, matching the bit layout of ex_to_mem_bus
    typedef struct packed {
        logic [13:0] sl_bus;
        logic [31:0] ex_pc;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_to_mem_t;

    // MEM->WB bus
    typedef struct packed {
        logic [31:0] mem_pc;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } mem_to_wb_t;

    // MEM->ID forwarding bus
    typedef struct packed {
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } mem_to_id_t;

    // A halfword load needs off[0]=0, a word load needs off=0; byte loads
    // and stores never flag.
    function automatic logic load_misaligned(input logic [13:0] sl,
                                             input logic [1:0]  off);
        logic half_bad;
        logic word_bad;
        half_bad = (sl[SL_LH] | sl[SL_LHU]) & off[0];
        word_bad = sl[SL_LW] & (off != 2'b00);
        return half_bad | word_bad;
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// mem_stage_load_align: picks the addressed byte or halfword out of the
// SRAM word and sign- or zero-extends it to 32 bits.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic        lb_i,
    input  logic        lbu_i,
    input  logic        lh_i,
    input  logic        lhu_i,
    input  logic        lw_i,
    output logic [31:0] result_o
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    // Lane selection: byte by full offset, halfword by offset[1]
    always_comb begin
        byteSel = word_i[7:0];
        case (offset_i)
            2'd0: byteSel = word_i[7:0];
            2'd1: byteSel = word_i[15:8];
            2'd2: byteSel = word_i[23:16];
            2'd3: byteSel = word_i[31:24];
            default: byteSel = word_i[7:0];
        endcase
        halfSel = offset_i[1] ? word_i[31:16] : word_i[15:0];
    end

    // Extension according to the load kind; anything else returns the word
    always_comb begin
        result_o = word_i;
        if (lw_i) begin
            result_o = word_i;
        end else if (lb_i) begin
            result_o = {{24{byteSel[7]}}, byteSel};
        end else if (lbu_i) begin
            result_o = {24'h0, byteSel};
        end else if (lh_i) begin
            result_o = {{16{halfSel[15]}}, halfSel};
        end else if (lhu_i) begin
            result_o = {16'h0, halfSel};
        end
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage between EX and WB. Registers the EX->MEM
// bus under the stall/bubble protocol, keeps SRAM load data in a hold
// buffer while MEM is stalled, aligns loads, selects the writeback value
// and drives the forwarding bus back to ID.
// Optional feature: define MEM_ADDR_EXC_EN to flag misaligned halfword/word
// loads (suppresses rf_we and raises mem_excp/mem_badvaddr).
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 32
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_BUS-1:0]    stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [DATA_W-1:0]       data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus,
    output logic                    mem_excp,
    output logic [31:0]             mem_badvaddr
);

    ex_to_mem_t        ex_to_mem_q;
    ex_to_mem_t        ex_to_mem_d;
    logic [DATA_W-1:0] rdata_buf_q;
    logic [DATA_W-1:0] rdata_buf_d;
    logic              rdata_vld_q;
    logic              rdata_vld_d;

    logic              memStop;
    logic              wbStop;
    logic              regWrite;

    logic [DATA_W-1:0] loadWord;
    logic [31:0]       alignedLoad;
    logic [1:0]        offset;
    logic [31:0]       rfWdata;
    logic              rfWe;
    mem_to_wb_t        wbBus;
    mem_to_id_t        idBus;

    assign memStop = (stall[STALL_MEM] == STOP);
    assign wbStop  = (stall[STALL_WB]  == STOP);

    // Stage register next state: bubble when MEM stops but WB drains,
    // load when MEM advances, otherwise hold the current instruction
    always_comb begin
        ex_to_mem_d = ex_to_mem_q;
        regWrite    = 1'b0;
        if (memStop && !wbStop) begin
            ex_to_mem_d = '0;
            regWrite    = 1'b1;
        end else if (!memStop) begin
            ex_to_mem_d = ex_to_mem_t'(ex_to_mem_bus);
            regWrite    = 1'b1;
        end
    end

    // Hold buffer next state: any write of the stage register invalidates
    // it; the first stalled cycle of a memory access latches the live SRAM
    // word, which is then reused until the stage moves on
    always_comb begin
        rdata_buf_d = rdata_buf_q;
        rdata_vld_d = rdata_vld_q;
        if (regWrite) begin
            rdata_vld_d = 1'b0;
        end else if (!rdata_vld_q && ex_to_mem_q.data_ram_en) begin
            rdata_buf_d = data_sram_rdata;
            rdata_vld_d = 1'b1;
        end
    end

    // Stage register and hold buffer, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_to_mem_q <= '0;
            rdata_buf_q <= '0;
            rdata_vld_q <= 1'b0;
        end else begin
            ex_to_mem_q <= ex_to_mem_d;
            rdata_buf_q <= rdata_buf_d;
            rdata_vld_q <= rdata_vld_d;
        end
    end

    // The buffered word wins over the live SRAM output once captured
    assign loadWord = rdata_vld_q ? rdata_buf_q : data_sram_rdata;
    assign offset   = ex_to_mem_q.ex_result[1:0];

    mem_stage_load_align u_load_align (
        .word_i   (loadWord[31:0]),
        .offset_i (offset),
        .lb_i     (ex_to_mem_q.sl_bus[SL_LB]),
        .lbu_i    (ex_to_mem_q.sl_bus[SL_LBU]),
        .lh_i     (ex_to_mem_q.sl_bus[SL_LH]),
        .lhu_i    (ex_to_mem_q.sl_bus[SL_LHU]),
        .lw_i     (ex_to_mem_q.sl_bus[SL_LW]),
        .result_o (alignedLoad)
    );

    assign rfWdata = ex_to_mem_q.sel_rf_res ? alignedLoad : ex_to_mem_q.ex_result;

`ifdef MEM_ADDR_EXC_EN
    logic misaligned;

    // A misaligned load must never reach the register file
    always_comb begin
        misaligned   = load_misaligned(ex_to_mem_q.sl_bus, offset);
        rfWe         = ex_to_mem_q.rf_we & ~misaligned;
        mem_excp     = misaligned;
        mem_badvaddr = misaligned ? ex_to_mem_q.ex_result : 32'h0;
    end
`else
    // Without exception support unused offset bits are simply ignored
    always_comb begin
        rfWe         = ex_to_mem_q.rf_we;
        mem_excp     = 1'b0;
        mem_badvaddr = 32'h0;
    end
`endif

    // Output bus assembly; a bubble (all-zero register) gives all-zero buses
    always_comb begin
        wbBus.mem_pc   = ex_to_mem_q.ex_pc;
        wbBus.rf_we    = rfWe;
        wbBus.rf_waddr = ex_to_mem_q.rf_waddr;
        wbBus.rf_wdata = rfWdata;
        idBus.rf_we    = rfWe;
        idBus.rf_waddr = ex_to_mem_q.rf_waddr;
        idBus.rf_wdata = rfWdata;
    end

    assign mem_to_wb_bus = wbBus;
    assign mem_to_id_bus = idBus;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage that sits directly downstream of EX and upstream of WB. It registers the EX→MEM bus under the stall/bubble protocol and captures synchronous data-SRAM read data. It aligns and extends load results, selects the register-file writeback value, and publishes a forwarding bus back to ID. A hold buffer preserves load data across MEM-stage stalls so that a stalled load never loses its SRAM return value.

## Interface
Parameters:
- DATA_W, 32, datapath and SRAM data width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- stall  in  6  pipeline stall vector; bit 3 = MEM, bit 4 = WB; `Stop`=1.
- ex_to_mem_bus  in  90  {sl_bus[89:76], ex_pc[75:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}.
- data_sram_rdata  in  32  SRAM read word, valid the cycle after EX presented the address.
- mem_to_wb_bus  out  70  {mem_pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}.
- mem_to_id_bus  out  38  {rf_we, rf_waddr, rf_wdata}, forwarding path.
- mem_excp  out  1  misaligned-load flag.
- mem_badvaddr  out  32  faulting address when mem_excp=1, else 0.

## Operation
- sl_bus encoding: [13] lw, [12] sw, [11] lb, [10] lbu, [9] lh, [8] lhu, [7] sb, [6] sh, [5:0] reserved and ignored.
- Pipeline register ex_to_mem_r:
  - rst → 0.
  - stall[3]=Stop and stall[4]=NoStop → 0 (bubble).
  - stall[3]=NoStop → load ex_to_mem_bus.
  - Otherwise hold.
- Hold buffer (rdata_buf, rdata_vld):
  - rdata_vld=0 with stall[3]=Stop and data_ram_en=1 → capture data_sram_rdata, set rdata_vld.
  - rdata_vld clears on any cycle ex_to_mem_r is written (load or bubble) and on rst.
  - Load word = rdata_vld ? rdata_buf : data_sram_rdata.
- Load alignment; off = ex_result[1:0]:
  - lb/lbu: byte off, sign-/zero-extended.
  - lh/lhu: halfword off[1], sign-/zero-extended.
  - lw: full word.
- rf_wdata = sel_rf_res ? aligned load : ex_result.
- Stores and non-memory instructions pass ex_result and rf_we unchanged.
- Bubble (all-zero register) yields all-zero outputs.

## Timing
- All outputs are combinational from ex_to_mem_r, the hold buffer and data_sram_rdata; there is no extra latency beyond the one-cycle stage register.
- Reset value of every output: 0.
- The stall vector is held for the full cycle; stall[3]=Stop with stall[4]=Stop holds everything, including the buffer.
- A load entering MEM in the same cycle as a stall: the buffer captures in that cycle and the value is used on every subsequent stalled cycle.
- Back-to-back loads: the buffer is cleared on advance, so the second load uses live rdata.
- rst mid-stall clears the register and the buffer in the same edge.

## Configuration
- MEM_ADDR_EXC_EN defined:
  - lh/lhu with off[0]≠0, or lw with off≠0, forces rf_we=0 on both output buses.
  - The same condition sets mem_excp=1 and mem_badvaddr=ex_result.
- MEM_ADDR_EXC_EN undefined:
  - Offset low bits not needed by the access are ignored (halfword uses off[1], word uses the full word).
  - mem_excp and mem_badvaddr are tied to 0.

## Structure
- defines.vh carries:
  - EX_TO_MEM_WD=90, MEM_TO_WB_WD=70, MEM_TO_ID_WD=38.
  - StallBus=6, Stop/NoStop.
  - sl_bus bit indices.
- Sub-module load_align: combinational; inputs are word, offset and the sl_bus load bits; output is the 32-bit extended result.

## Test plan
- lb at addr 0x...3 with rdata 0x80FF_1234 → rf_wdata 0xFFFF_FF80; lbu at the same address → 0x0000_0080.
- lh at offset 2 with rdata 0x8001_7FFF → 0xFFFF_8001; lhu at offset 0 → 0x0000_7FFF.
- lw with rdata 0xDEAD_BEEF, stall[3]=Stop for 3 cycles, rdata changed to 0 in cycle 2 → rf_wdata remains 0xDEAD_BEEF for all 3 cycles and on release.
- stall[3]=Stop with stall[4]=NoStop → next cycle all output buses are 0; rst asserted mid-stall → all outputs 0 and rdata_vld=0.
- With MEM_ADDR_EXC_EN, lw at 0x1002 with rf_we=1 → rf_we=0, mem_excp=1, mem_badvaddr=0x1002; without the macro → rf_we=1, word returned, mem_excp=0.
- ALU result 0x0000_0055 with sel_rf_res=0, rf_waddr=5 → mem_to_id_bus={1,5,0x55} in the same cycle the instruction occupies MEM.
